// File: rtl/dac_serial_multich.sv
// ---------------------------------------------------------------------------
// dac_serial_multich
// Serial-in, multi-channel DAC register model. Frames of FRAME_W bits are
// shifted in MSB first while SYNC_b is low. Data frames write a channel's
// input register. Control frames set the LDAC mode, the power mask, or
// clear registers. DAC registers copy the input registers under pin,
// auto-update or single-shot LDAC control.
//
// Ports:
//   SCLK       serial clock, all logic on its rising edge
//   RESET_b    synchronous active-low reset
//   SYNC_b     active-low frame enable
//   DIN        serial data, MSB first
//   LDAC_b     active-low load pin (pin mode only)
//   VOUT       DAC values, channel k at [k*DATA_W +: DATA_W], 0 when powered down
//   CH_ON      per-channel power-up mask
//   LDAC_MODE  current LDAC mode (00 pin, 01 auto, 10 single-shot)
//   BUSY       frame in progress
//   FRAME_ERR  one-cycle pulse on a short frame
//   OVR_ERR    one-cycle pulse on an overlong frame
// ---------------------------------------------------------------------------
module dac_serial_multich #(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 10,
    parameter int FRAME_W = 16
) (
    input  logic                     SCLK,
    input  logic                     RESET_b,
    input  logic                     SYNC_b,
    input  logic                     DIN,
    input  logic                     LDAC_b,
    output logic [NUM_CH*DATA_W-1:0] VOUT,
    output logic [NUM_CH-1:0]        CH_ON,
    output logic [1:0]               LDAC_MODE,
    output logic                     BUSY,
    output logic                     FRAME_ERR,
    output logic                     OVR_ERR
);

    localparam int CH_AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam int P_W   = FRAME_W - 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_W + 1);

    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shift_q;
    logic               armed;
    logic               ss_flag;
    logic               data_done;
    logic [DATA_W-1:0]  in_reg  [NUM_CH];
    logic [DATA_W-1:0]  dac_reg [NUM_CH];

    logic [FRAME_W-1:0] word;
    logic               sample;
    logic               complete;
    logic               is_data;
    logic               is_ctrl;
    logic [1:0]         opcode;
    logic [P_W-1:0]     payload;
    logic [CH_AW-1:0]   addr;
    logic [DATA_W-1:0]  data;
    logic               load;
    logic               unused_payload;

    // The completing edge decodes the frame including the bit on DIN now.
    assign sample   = !SYNC_b && armed && (bit_cnt < CNT_FULL);
    assign complete = sample && (bit_cnt == CNT_LAST);
    assign word     = {shift_q, DIN};
    assign is_data  = complete && !word[FRAME_W-1];
    assign is_ctrl  = complete && word[FRAME_W-1];
    assign opcode   = word[FRAME_W-2 -: 2];
    assign payload  = word[P_W-1:0];
    assign addr     = word[FRAME_W-2 -: CH_AW];
    assign data     = word[FRAME_W-2-CH_AW -: DATA_W];
    assign BUSY     = (bit_cnt != '0) && (bit_cnt < CNT_FULL);

    assign unused_payload = ^payload;

    // Load request: a pending single-shot overrides the pin; auto mode loads
    // one edge after a data frame; pin mode follows LDAC_b.
    always_comb begin
        load = 1'b0;
        if (ss_flag)
            load = data_done;
        else if (LDAC_MODE == 2'b01)
            load = data_done;
        else if (LDAC_MODE == 2'b00)
            load = !LDAC_b;
    end

    // Framing: bit counter, shift register and error pulses. After a frame
    // completes the counter runs one step further so the overlong pulse
    // fires exactly once, then it saturates until SYNC_b returns high.
    always_ff @(posedge SCLK) begin
        if (!RESET_b) begin
            bit_cnt   <= '0;
            shift_q   <= '0;
            armed     <= 1'b1;
            FRAME_ERR <= 1'b0;
            OVR_ERR   <= 1'b0;
        end else begin
            FRAME_ERR <= 1'b0;
            OVR_ERR   <= 1'b0;
            if (SYNC_b) begin
                armed   <= 1'b1;
                bit_cnt <= '0;
                if (BUSY)
                    FRAME_ERR <= 1'b1;
            end else if (sample) begin
                shift_q <= word[FRAME_W-2:0];
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (complete)
                    armed <= 1'b0;
            end else if (bit_cnt == CNT_FULL) begin
                bit_cnt <= CNT_OVR;
                OVR_ERR <= 1'b1;
            end
        end
    end

    // Register file and control state. Later assignments take priority, so
    // the load copies pre-update input values and a reset opcode beats a load.
    always_ff @(posedge SCLK) begin
        if (!RESET_b) begin
            for (int k = 0; k < NUM_CH; k++) begin
                in_reg[k]  <= '0;
                dac_reg[k] <= '0;
            end
            CH_ON     <= '0;
            LDAC_MODE <= 2'b00;
            ss_flag   <= 1'b0;
            data_done <= 1'b0;
        end else begin
            data_done <= is_data;
            if (load) begin
                for (int k = 0; k < NUM_CH; k++)
                    dac_reg[k] <= in_reg[k];
                if (ss_flag) begin
                    ss_flag   <= 1'b0;
                    LDAC_MODE <= 2'b00;
                end
            end
            if (is_data)
                in_reg[addr] <= data;
            if (is_ctrl) begin
                case (opcode)
                    2'b00: begin
                        if (payload[1:0] != 2'b11) begin
                            LDAC_MODE <= payload[1:0];
                            ss_flag   <= (payload[1:0] == 2'b10);
                        end
                    end
                    2'b01: CH_ON <= payload[NUM_CH-1:0];
                    2'b11: begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            in_reg[k]  <= '0;
                            dac_reg[k] <= '0;
                        end
                        if (payload[0]) begin
                            CH_ON     <= '0;
                            LDAC_MODE <= 2'b00;
                            ss_flag   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Powered-down channels read 0 but keep their DAC register contents.
    always_comb begin
        VOUT = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (CH_ON[k])
                VOUT[k*DATA_W +: DATA_W] = dac_reg[k];
    end

endmodule

// File: tb/tb_dac_serial_multich.sv
// ---------------------------------------------------------------------------
// tb_dac_serial_multich
// Self-checking bench for dac_serial_multich (8 channels, 10 bits, 16-bit
// frames). Every edge is compared against a frame-level reference model;
// a table of frames and hand-written sequences check fixed expected values.
// ---------------------------------------------------------------------------
module tb_dac_serial_multich;

    logic        SCLK;
    logic        rstB, syncB, din, ldacB;
    logic [79:0] vout;
    logic [7:0]  chOn;
    logic [1:0]  ldacMode;
    logic        busy, frameErr, ovrErr;

    int nVec = 0;
    int nErr = 0;

    dac_serial_multich #(.NUM_CH(8), .DATA_W(10), .FRAME_W(16)) dut (
        .SCLK(SCLK), .RESET_b(rstB), .SYNC_b(syncB), .DIN(din), .LDAC_b(ldacB),
        .VOUT(vout), .CH_ON(chOn), .LDAC_MODE(ldacMode), .BUSY(busy),
        .FRAME_ERR(frameErr), .OVR_ERR(ovrErr)
    );

    initial begin
        SCLK = 1'b0;
        forever #5 SCLK = ~SCLK;
    end

    // Reference model state, kept at frame level: a bit count since SYNC_b
    // went high and the word collected from the first 16 bits.
    logic [9:0]  mIn  [8];
    logic [9:0]  mDac [8];
    logic [7:0]  mChOn;
    logic [1:0]  mMode;
    bit          mSs, mPend, mFerr, mOerr;
    int          mBits;
    logic [15:0] mWord;

    task automatic executeFrame(input logic [15:0] w, output bit newPend);
        newPend = 0;
        if (!w[15]) begin
            mIn[w[14:12]] = w[11:2];
            newPend = 1;
        end else begin
            case (w[14:13])
                2'd0: if (w[1:0] != 2'd3) begin
                    mMode = w[1:0];
                    mSs   = (w[1:0] == 2'd2);
                end
                2'd1: mChOn = w[7:0];
                2'd3: begin
                    for (int k = 0; k < 8; k++) begin
                        mIn[k]  = '0;
                        mDac[k] = '0;
                    end
                    if (w[0]) begin
                        mChOn = '0;
                        mMode = 2'd0;
                        mSs   = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic modelStep();
        bit doLoad, newPend;
        newPend = 0;
        if (!rstB) begin
            for (int k = 0; k < 8; k++) begin
                mIn[k]  = '0;
                mDac[k] = '0;
            end
            mChOn = '0; mMode = 2'd0; mSs = 0; mPend = 0;
            mFerr = 0; mOerr = 0; mBits = 0; mWord = '0;
            return;
        end
        mFerr = 0;
        mOerr = 0;
        if (mSs)              doLoad = mPend;
        else if (mMode == 1)  doLoad = mPend;
        else if (mMode == 0)  doLoad = !ldacB;
        else                  doLoad = 0;
        if (doLoad) begin
            for (int k = 0; k < 8; k++) mDac[k] = mIn[k];
            if (mSs) begin
                mSs   = 0;
                mMode = 2'd0;
            end
        end
        if (syncB) begin
            if (mBits > 0 && mBits < 16) mFerr = 1;
            mBits = 0;
            mWord = '0;
        end else begin
            mBits++;
            if (mBits <= 16) mWord = {mWord[14:0], din};
            if (mBits == 16) executeFrame(mWord, newPend);
            if (mBits == 17) mOerr = 1;
        end
        mPend = newPend;
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic d, input logic l);
        rstB  = r;
        syncB = s;
        din   = d;
        ldacB = l;
    endtask

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One rising edge: advance the model with the inputs seen at the edge,
    // then compare every output shortly after the edge.
    task automatic tick();
        logic [79:0] expVout;
        logic        expBusy;
        @(posedge SCLK);
        modelStep();
        #1;
        expVout = '0;
        for (int k = 0; k < 8; k++)
            if (mChOn[k]) expVout[k*10 +: 10] = mDac[k];
        expBusy = (mBits > 0 && mBits < 16);
        checkOutput("model", {3'b0, vout, chOn, ldacMode, busy, frameErr, ovrErr},
                    {3'b0, expVout, mChOn, mMode, expBusy, mFerr, mOerr});
    endtask

    task automatic sendBits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, (i < 16) ? w[15-i] : 1'($urandom), 1'b1);
            tick();
        end
    endtask

    task automatic sendFrame(input logic [15:0] w);
        sendBits(w, 16);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
    endtask

    task automatic pulseLdac();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
    endtask

    typedef struct {
        logic [15:0] frame;
        int          nbits;
        bit          pulse;
        int          ch;
        logic [9:0]  expVal;
        logic [7:0]  expChOn;
        logic [1:0]  expMode;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] w;
        int len, r, rstAt, gap;

        tbl[0] = '{16'hA0FF, 16, 1'b0, 2, 10'h000, 8'hFF, 2'd0};
        tbl[1] = '{16'h2554, 16, 1'b1, 2, 10'h155, 8'hFF, 2'd0};
        tbl[2] = '{16'h0FFC, 16, 1'b0, 0, 10'h000, 8'hFF, 2'd0};
        tbl[3] = '{16'h0000,  0, 1'b1, 0, 10'h3FF, 8'hFF, 2'd0};
        tbl[4] = '{16'h8001, 16, 1'b0, 7, 10'h000, 8'hFF, 2'd1};
        tbl[5] = '{16'h7800, 16, 1'b0, 7, 10'h200, 8'hFF, 2'd1};
        tbl[6] = '{16'h8002, 16, 1'b0, 7, 10'h200, 8'hFF, 2'd2};
        tbl[7] = '{16'h12A8, 16, 1'b0, 1, 10'h0AA, 8'hFF, 2'd0};
        tbl[8] = '{16'h1154, 16, 1'b0, 1, 10'h0AA, 8'hFF, 2'd0};

        // Reset state
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("reset vout",  {16'b0, vout}, 96'd0);
        checkOutput("reset ch_on", {88'b0, chOn}, 96'd0);
        checkOutput("reset mode",  {94'b0, ldacMode}, 96'd0);
        checkOutput("reset busy",  {95'b0, busy}, 96'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();

        // Table of frames with fixed expectations
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].nbits > 0) sendFrame(tbl[i].frame);
            if (tbl[i].pulse) pulseLdac();
            checkOutput($sformatf("tbl%0d vout ch%0d", i, tbl[i].ch),
                        {86'b0, vout[tbl[i].ch*10 +: 10]}, {86'b0, tbl[i].expVal});
            checkOutput($sformatf("tbl%0d ch_on", i), {88'b0, chOn}, {88'b0, tbl[i].expChOn});
            checkOutput($sformatf("tbl%0d mode", i), {94'b0, ldacMode}, {94'b0, tbl[i].expMode});
        end

        // Short frame: 9 bits then SYNC_b high
        sendBits(16'h3FFC, 9);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("short ferr", {95'b0, frameErr}, 96'd1);
        tick();
        checkOutput("short ferr clear", {95'b0, frameErr}, 96'd0);
        pulseLdac();
        checkOutput("short ch3", {86'b0, vout[30 +: 10]}, 96'd0);
        checkOutput("pulse ch1", {86'b0, vout[10 +: 10]}, 96'h055);

        // Long frame: 18 bits, one overrun pulse at bit 17
        sendBits(16'h448C, 16);
        checkOutput("long busy at 16", {95'b0, busy}, 96'd0);
        checkOutput("long ovr at 16", {95'b0, ovrErr}, 96'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("long ovr at 17", {95'b0, ovrErr}, 96'd1);
        tick();
        checkOutput("long ovr at 18", {95'b0, ovrErr}, 96'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("long no ferr", {95'b0, frameErr}, 96'd0);
        pulseLdac();
        checkOutput("long ch4", {86'b0, vout[40 +: 10]}, 96'h123);

        // Power mask retains DAC registers
        sendFrame(16'hA00F);
        checkOutput("mask ch4 off", {86'b0, vout[40 +: 10]}, 96'd0);
        checkOutput("mask ch0 on", {86'b0, vout[0 +: 10]}, 96'h3FF);
        checkOutput("mask ch_on", {88'b0, chOn}, 96'h0F);
        sendFrame(16'hA0FF);
        checkOutput("restore ch4", {86'b0, vout[40 +: 10]}, 96'h123);

        // Soft then full reset opcodes
        sendFrame(16'h8001);
        sendFrame(16'hE000);
        checkOutput("soft vout", {16'b0, vout}, 96'd0);
        checkOutput("soft ch_on", {88'b0, chOn}, 96'hFF);
        checkOutput("soft mode", {94'b0, ldacMode}, 96'd1);
        sendFrame(16'hE001);
        checkOutput("full ch_on", {88'b0, chOn}, 96'd0);
        checkOutput("full mode", {94'b0, ldacMode}, 96'd0);

        // Reset pin mid-frame
        sendBits(16'h2554, 5);
        checkOutput("mid busy", {95'b0, busy}, 96'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("mid rst busy", {95'b0, busy}, 96'd0);
        checkOutput("mid rst ferr", {95'b0, frameErr}, 96'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("mid rel ferr", {95'b0, frameErr}, 96'd0);

        // Randomized frames against the model
        for (int f = 0; f < 400; f++) begin
            w = 16'($urandom);
            if (w[15] && w[14:13] == 2'd3 && $urandom_range(0, 3) != 0) w[14:13] = 2'd1;
            r = $urandom_range(0, 99);
            if (r < 70)      len = 16;
            else if (r < 85) len = $urandom_range(1, 15);
            else             len = $urandom_range(17, 19);
            rstAt = ($urandom_range(0, 49) == 0) ? $urandom_range(0, len - 1) : -1;
            for (int i = 0; i < len; i++) begin
                applyStimulus((i == rstAt) ? 1'b0 : 1'b1, 1'b0,
                              (i < 16) ? w[15-i] : 1'($urandom),
                              ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1);
                tick();
            end
            gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b1, 1'b1, 1'($urandom),
                              ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/dac_serial_multich.md
Name: dac_serial_multich

Overview:
- Parametrised successor of the 8-channel AD5318-style DAC model: a serial-in, multi-channel DAC register model with configurable channel count, resolution and frame length.
- Fully synchronous to SCLK. Adds frame-length error detection, selectable LDAC modes including single-shot, per-channel power masks, two reset depths and status outputs.
- Sits at the DAC interface of the SPI-style controller benches, replacing the fixed-width model.

Parameters:
- NUM_CH, 8: channel count; power of 2, 2..16; NUM_CH <= FRAME_W-3.
- DATA_W, 10: DAC resolution in bits.
- FRAME_W, 16: serial frame length; 1+CH_AW+DATA_W <= FRAME_W, where CH_AW = clog2(NUM_CH).

Ports:
- SCLK  in  1  serial clock, the only clock; all logic on its rising edge.
- RESET_b  in  1  reset, synchronous, active-low.
- SYNC_b  in  1  frame enable, active-low, sampled on SCLK.
- DIN  in  1  serial data, MSB first, sampled while SYNC_b low.
- LDAC_b  in  1  load DAC pin, active-low, sampled on SCLK.
- VOUT  out  NUM_CH*DATA_W  DAC register values; channel k occupies [k*DATA_W +: DATA_W].
- CH_ON  out  NUM_CH  1 = channel powered up.
- LDAC_MODE  out  2  current LDAC mode.
- BUSY  out  1  frame in progress.
- FRAME_ERR  out  1  one-cycle pulse on a short frame.
- OVR_ERR  out  1  one-cycle pulse on an overlong frame.

Behaviour:
- Reset (RESET_b sampled low):
  - bit counter = 0; shift register = 0; all input and DAC registers = 0.
  - CH_ON = 0 (all powered down); LDAC_MODE = 00; single-shot flag = 0.
  - BUSY, FRAME_ERR and OVR_ERR = 0; the armed flag is set (SYNC_b treated as high).
- Reset asserted mid-frame discards the frame with no error pulse.
- Framing:
  - The counter increments and DIN shifts in on each edge where SYNC_b = 0 and the interface is armed.
  - BUSY = 1 while 0 < count < FRAME_W.
  - The edge that samples bit FRAME_W completes the frame. Decode uses the full word {shift, DIN} and executes at that edge.
  - After completion, further bits are ignored. OVR_ERR pulses once, at the edge sampling bit FRAME_W+1; the completed frame is not undone.
  - SYNC_b sampled high re-arms and clears the counter. If the counter was 1..FRAME_W-1 at that point, the frame is discarded and FRAME_ERR pulses for one cycle.
  - SYNC_b must be sampled high at least one edge between frames.
- Frame format, bit FRAME_W-1 = C:
  - C = 0, data frame: next CH_AW bits = channel address, next DATA_W bits = data, remaining low bits don't care. The input register is updated at the completing edge.
  - C = 1, control frame: bits [FRAME_W-2:FRAME_W-3] = opcode, low bits = payload P.
- Opcode 00, LDAC mode: LDAC_MODE <= P[1:0].
  - 00: pin mode.
  - 01: auto-update.
  - 10: single-shot, which also sets the single-shot flag.
  - 11: reserved; frame ignored, mode unchanged.
- Opcode 01, power: CH_ON <= P[NUM_CH-1:0].
- Opcode 10, reserved: no effect.
- Opcode 11, reset:
  - P[0] = 0: clear all input and DAC registers.
  - P[0] = 1: additionally clear CH_ON, LDAC_MODE and the single-shot flag.
- DAC register load, all channels copy their input registers:
  - Mode 00: on every edge where LDAC_b is sampled 0.
  - Mode 01: the edge after any data frame completes (latency 1).
  - Mode 10: the edge after the next completed data frame; then the flag clears and LDAC_MODE returns to 00. LDAC_b is ignored while the flag is set.
- Simultaneous events:
  - A load and a data-frame completion on the same edge: the load copies the pre-update input value.
  - A reset opcode and a load on the same edge: the clear wins.
- Output: VOUT slice = DAC register when CH_ON[k] = 1, else 0. The DAC register is retained while powered down.
- Address width: an address with unused MSBs (not applicable when NUM_CH is a power of 2) wraps modulo NUM_CH.

Test Plan:
- Power-up + power: reset, send control 0xA0FF (power all on), then data ch2 = 0x155 via 0x2554, LDAC_b = 0 for 1 edge -> VOUT ch2 = 0x155, CH_ON = 0xFF, other channels 0.
- LDAC pin hold: mode 00, LDAC_b = 1, write ch0 = 0x3FF -> VOUT ch0 stays 0; pulse LDAC_b low -> ch0 = 0x3FF on the next edge.
- Auto/single-shot: mode 01, write ch7 = 0x200 -> VOUT ch7 = 0x200 one edge after completion. Mode 10, write ch1 = 0x0AA -> ch1 loads once and LDAC_MODE reads 00 afterwards; a second write does not load without LDAC_b.
- Short/long frames: SYNC_b high after 9 bits -> FRAME_ERR pulse, no register change. 18 bits in one frame -> frame executes, one OVR_ERR pulse at bit 17.
- Power mask: CH_ON = 0x0F -> VOUT ch4..7 = 0 while their DAC registers are retained. Restore 0xFF -> previous values reappear.
- Reset opcodes: soft reset (P[0] = 0) -> VOUT all 0, CH_ON unchanged. Full reset (P[0] = 1) -> CH_ON = 0, LDAC_MODE = 00. RESET_b low mid-frame -> BUSY = 0, no error pulse.
